// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   localparam int unsigned MEM_LAT_DEF = 2;
   localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: a lone requester always wins, a tie goes
// to whoever did not win last. The last winner is remembered on issue.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   ireq_i,
   input  logic   dreq_i,
   input  logic   issue_i,
   output grant_t grant_o
);

   grant_t last_q;
   grant_t last_d;

   // Grant selection: tie broken against the previous winner.
   always_comb begin
      grant_o = GRANT_I;
      last_d  = last_q;
      if (ireq_i && dreq_i) begin
         grant_o = (last_q == GRANT_I) ? GRANT_D : GRANT_I;
      end else if (dreq_i) begin
         grant_o = GRANT_D;
      end
      if (issue_i) begin
         last_d = grant_o;
      end
   end

   // Last-grant register; resets to I so the first tie after reset favours D.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= GRANT_I;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction fetch port and a data
// port. Writes complete in the issue cycle; reads wait MEM_LAT cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        IReq,
   input  logic [31:0] IAddr,
   output logic [31:0] IData,
   output logic        IReady,
   input  logic        DReq,
   input  logic        DWe,
   input  logic [31:0] DAddr,
   input  logic [31:0] DWData,
   output logic [31:0] DRData,
   output logic        DReady,
   output logic        MemEn,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData,
   output logic        Stall
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   grant_t            wgnt_q, wgnt_d;
   logic [31:0]       idata_q, idata_d;
   logic [31:0]       drdata_q, drdata_d;
   grant_t            grant;
   logic              issue;

   rr_arb2 u_arb (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .ireq_i  (IReq),
      .dreq_i  (DReq),
      .issue_i (issue),
      .grant_o (grant)
   );

   // Next-state and memory/handshake outputs; everything idles while Reset is high.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wgnt_d   = wgnt_q;
      idata_d  = idata_q;
      drdata_d = drdata_q;
      issue    = 1'b0;
      MemEn    = 1'b0;
      MemWe    = 1'b0;
      MemAddr  = '0;
      MemWData = '0;
      IReady   = 1'b0;
      DReady   = 1'b0;
      IData    = idata_q;
      DRData   = drdata_q;
      if (!Reset) begin
         case (state_q)
            IDLE: begin
               if (IReq || DReq) begin
                  issue = 1'b1;
                  MemEn = 1'b1;
                  if (grant == GRANT_D) begin
                     MemAddr = DAddr;
                     if (DWe) begin
                        MemWe    = 1'b1;
                        MemWData = DWData;
                        DReady   = 1'b1;
                     end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                        wgnt_d  = GRANT_D;
                     end
                  end else begin
                     MemAddr = IAddr;
                     state_d = WAIT;
                     cnt_d   = CNT_LOAD;
                     wgnt_d  = GRANT_I;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
                  if (wgnt_q == GRANT_I) begin
                     IReady  = 1'b1;
                     IData   = MemRData;
                     idata_d = MemRData;
                  end else begin
                     DReady   = 1'b1;
                     DRData   = MemRData;
                     drdata_d = MemRData;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, latency counter and captured read data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wgnt_q   <= GRANT_I;
         idata_q  <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wgnt_q   <= wgnt_d;
         idata_q  <= idata_d;
         drdata_q <= drdata_d;
      end
   end

   assign Stall = (IReq && !IReady) || (DReq && !DReady);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance exercised on
// arbitration, writes, continuous reads and reset abort, plus a MEM_LAT=1
// instance for back-to-back fetch reads.
module tb_mem_port_arbiter;

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic        we;
      logic [31:0] d;
   } ev_t;

   logic        Clk = 1'b0;
   logic        Reset;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   // instance 0 (MEM_LAT = 2)
   logic        IReq, DReq, DWe;
   logic [31:0] IAddr, DAddr, DWData;
   logic [31:0] IData, DRData, MemAddr, MemWData, MemRData;
   logic        IReady, DReady, MemEn, MemWe, Stall;
   logic [31:0] p0a = 32'hBADBAD00;
   logic [31:0] p0b = 32'hBADBAD00;

   // instance 1 (MEM_LAT = 1)
   logic        bIReq;
   logic [31:0] bIAddr;
   logic [31:0] bIData, bDRData, bMemAddr, bMemWData, bMemRData;
   logic        bIReady, bDReady, bMemEn, bMemWe, bStall;
   logic [31:0] p1a = 32'hBADBAD00;

   ev_t iss_q[$];
   ev_t ir_q[$];
   ev_t dr_q[$];
   ev_t iss1_q[$];
   ev_t ir1_q[$];

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   mem_port_arbiter u0 (
      .Clk(Clk), .Reset(Reset),
      .IReq(IReq), .IAddr(IAddr), .IData(IData), .IReady(IReady),
      .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
      .DRData(DRData), .DReady(DReady),
      .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemRData(MemRData), .Stall(Stall)
   );

   mem_port_arbiter #(.MEM_LAT(1)) u1 (
      .Clk(Clk), .Reset(Reset),
      .IReq(bIReq), .IAddr(bIAddr), .IData(bIData), .IReady(bIReady),
      .DReq(1'b0), .DWe(1'b0), .DAddr(32'h0), .DWData(32'h0),
      .DRData(bDRData), .DReady(bDReady),
      .MemEn(bMemEn), .MemWe(bMemWe), .MemAddr(bMemAddr), .MemWData(bMemWData),
      .MemRData(bMemRData), .Stall(bStall)
   );

   // memory contents for the addresses the stimulus reads
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      case (a)
         32'h0000_0040: mem_fn = 32'h2008_0005;
         32'h0000_0044: mem_fn = 32'h1357_9BDF;
         32'h0000_0048: mem_fn = 32'h0F0F_0F0F;
         32'h0000_0050: mem_fn = 32'h0123_4567;
         32'h0000_0054: mem_fn = 32'h89AB_CDEF;
         32'h0000_0100: mem_fn = 32'h5A5A_0100;
         32'h0000_0104: mem_fn = 32'h2468_ACE0;
         32'h0000_0108: mem_fn = 32'hF00D_F00D;
         default:       mem_fn = 32'hBADB_AD00;
      endcase
   endfunction

   // memory read pipelines: data appears MEM_LAT cycles after the read issue
   always @(posedge Clk) begin
      p0a <= (MemEn && !MemWe) ? mem_fn(MemAddr) : 32'hBADBAD00;
      p0b <= p0a;
      p1a <= (bMemEn && !bMemWe) ? mem_fn(bMemAddr) : 32'hBADBAD00;
   end
   assign MemRData  = p0b;
   assign bMemRData = p1a;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      total++;
      bad++;
      $display("FAIL %s at cycle %0d: got event expected none", nm, cyc);
   endtask

   function automatic ev_t mk(input int c, input logic [31:0] a, input logic we,
                              input logic [31:0] d);
      ev_t e;
      e.cyc = c; e.a = a; e.we = we; e.d = d;
      return e;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // scoreboard monitor for instance 0
   always @(negedge Clk) begin
      ev_t e;
      if (MemEn === 1'b1) begin
         if (iss_q.size() == 0) unexpected("issue0");
         else begin
            e = iss_q.pop_front();
            chk("issue0_cyc", 32'(cyc), 32'(e.cyc));
            chk("issue0_addr", MemAddr, e.a);
            chk("issue0_we", {31'b0, MemWe}, {31'b0, e.we});
            chk("issue0_wdata", MemWData, e.d);
         end
      end else begin
         chk("idle0_bus", MemAddr | MemWData | {31'b0, MemWe}, 32'h0);
      end
      if (IReady === 1'b1) begin
         if (ir_q.size() == 0) unexpected("iready0");
         else begin
            e = ir_q.pop_front();
            chk("iready0_cyc", 32'(cyc), 32'(e.cyc));
            chk("iready0_data", IData, e.a);
         end
      end
      if (DReady === 1'b1) begin
         if (dr_q.size() == 0) unexpected("dready0");
         else begin
            e = dr_q.pop_front();
            chk("dready0_cyc", 32'(cyc), 32'(e.cyc));
            chk("dready0_data", DRData, e.a);
         end
      end
      if (IReady === 1'b1 && DReady === 1'b1) unexpected("both_ready0");
   end

   // scoreboard monitor for instance 1
   always @(negedge Clk) begin
      ev_t e;
      if (bMemEn === 1'b1) begin
         if (iss1_q.size() == 0) unexpected("issue1");
         else begin
            e = iss1_q.pop_front();
            chk("issue1_cyc", 32'(cyc), 32'(e.cyc));
            chk("issue1_addr", bMemAddr, e.a);
            chk("issue1_we", {31'b0, bMemWe}, 32'h0);
            chk("issue1_wdata", bMemWData, 32'h0);
         end
      end
      if (bIReady === 1'b1) begin
         if (ir1_q.size() == 0) unexpected("iready1");
         else begin
            e = ir1_q.pop_front();
            chk("iready1_cyc", 32'(cyc), 32'(e.cyc));
            chk("iready1_data", bIData, e.a);
         end
      end
      if (bDReady === 1'b1) unexpected("dready1");
   end

   initial begin
      int t;
      Reset = 1'b1;
      IReq = 1'b1; IAddr = 32'h40;
      DReq = 1'b0; DWe = 1'b0; DAddr = 32'h0; DWData = 32'h0;
      bIReq = 1'b0; bIAddr = 32'h0;

      // reset cycle with a pending fetch: nothing may issue or complete
      step();
      @(negedge Clk);
      chk("rst_memen", {31'b0, MemEn}, 32'h0);
      chk("rst_iready", {31'b0, IReady}, 32'h0);
      chk("rst_dready", {31'b0, DReady}, 32'h0);
      IReq = 1'b0;
      step();
      Reset = 1'b0;
      @(negedge Clk);
      chk("rst_idata", IData, 32'h0);
      chk("rst_drdata", DRData, 32'h0);
      chk("rst_stall", {31'b0, Stall}, 32'h0);

      // single fetch read, data held afterwards
      step();
      t = cyc;
      IReq = 1'b1; IAddr = 32'h40;
      iss_q.push_back(mk(t, 32'h40, 1'b0, 32'h0));
      ir_q.push_back(mk(t + 2, 32'h2008_0005, 1'b0, 32'h0));
      @(negedge Clk); chk("stall_a0", {31'b0, Stall}, 32'h1);
      step();
      @(negedge Clk); chk("stall_a1", {31'b0, Stall}, 32'h1);
      step();
      @(negedge Clk); chk("stall_a2", {31'b0, Stall}, 32'h0);
      step();
      IReq = 1'b0;
      @(negedge Clk); chk("hold_a3", IData, 32'h2008_0005);
      step(); step();
      @(negedge Clk); chk("hold_a5", IData, 32'h2008_0005);

      // tie right after reset: D read first, then I
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      t = cyc;
      IReq = 1'b1; IAddr = 32'h44;
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h100;
      iss_q.push_back(mk(t, 32'h100, 1'b0, 32'h0));
      dr_q.push_back(mk(t + 2, 32'h5A5A_0100, 1'b0, 32'h0));
      iss_q.push_back(mk(t + 3, 32'h44, 1'b0, 32'h0));
      ir_q.push_back(mk(t + 5, 32'h1357_9BDF, 1'b0, 32'h0));
      repeat (3) step();
      DReq = 1'b0;
      repeat (3) step();
      IReq = 1'b0;

      // D write completes in its issue cycle, I read issues next cycle
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      t = cyc;
      DReq = 1'b1; DWe = 1'b1; DAddr = 32'h200; DWData = 32'hDEAD_BEEF;
      IReq = 1'b1; IAddr = 32'h40;
      iss_q.push_back(mk(t, 32'h200, 1'b1, 32'hDEAD_BEEF));
      dr_q.push_back(mk(t, 32'h0, 1'b0, 32'h0));
      iss_q.push_back(mk(t + 1, 32'h40, 1'b0, 32'h0));
      ir_q.push_back(mk(t + 3, 32'h2008_0005, 1'b0, 32'h0));
      step();
      DReq = 1'b0; DWe = 1'b0; DWData = 32'h0;
      repeat (3) step();
      IReq = 1'b0;

      // both reading continuously: D,I,D,I three cycles apart
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      t = cyc;
      IReq = 1'b1; IAddr = 32'h44;
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h104;
      iss_q.push_back(mk(t, 32'h104, 1'b0, 32'h0));
      dr_q.push_back(mk(t + 2, 32'h2468_ACE0, 1'b0, 32'h0));
      iss_q.push_back(mk(t + 3, 32'h44, 1'b0, 32'h0));
      ir_q.push_back(mk(t + 5, 32'h1357_9BDF, 1'b0, 32'h0));
      iss_q.push_back(mk(t + 6, 32'h104, 1'b0, 32'h0));
      dr_q.push_back(mk(t + 8, 32'h2468_ACE0, 1'b0, 32'h0));
      iss_q.push_back(mk(t + 9, 32'h44, 1'b0, 32'h0));
      ir_q.push_back(mk(t + 11, 32'h1357_9BDF, 1'b0, 32'h0));
      for (int k = 0; k < 12; k++) begin
         @(negedge Clk); chk("stall_both", {31'b0, Stall}, 32'h1);
         step();
      end
      IReq = 1'b0; DReq = 1'b0;

      // reset during an I read: read aborted, D wins the first tie after
      step();
      t = cyc;
      IReq = 1'b1; IAddr = 32'h48;
      iss_q.push_back(mk(t, 32'h48, 1'b0, 32'h0));
      step();
      Reset = 1'b1;
      DReq = 1'b1; DWe = 1'b0; DAddr = 32'h108;
      @(negedge Clk);
      chk("abort_memen", {31'b0, MemEn}, 32'h0);
      chk("abort_iready", {31'b0, IReady}, 32'h0);
      step();
      Reset = 1'b0;
      iss_q.push_back(mk(t + 2, 32'h108, 1'b0, 32'h0));
      dr_q.push_back(mk(t + 4, 32'hF00D_F00D, 1'b0, 32'h0));
      iss_q.push_back(mk(t + 5, 32'h48, 1'b0, 32'h0));
      ir_q.push_back(mk(t + 7, 32'h0F0F_0F0F, 1'b0, 32'h0));
      @(negedge Clk);
      chk("abort_idata", IData, 32'h0);
      chk("abort_drdata", DRData, 32'h0);
      repeat (3) step();
      DReq = 1'b0;
      repeat (3) step();
      IReq = 1'b0;

      // MEM_LAT=1: back-to-back fetch reads every two cycles
      step();
      t = cyc;
      bIReq = 1'b1; bIAddr = 32'h50;
      iss1_q.push_back(mk(t, 32'h50, 1'b0, 32'h0));
      ir1_q.push_back(mk(t + 1, 32'h0123_4567, 1'b0, 32'h0));
      iss1_q.push_back(mk(t + 2, 32'h54, 1'b0, 32'h0));
      ir1_q.push_back(mk(t + 3, 32'h89AB_CDEF, 1'b0, 32'h0));
      iss1_q.push_back(mk(t + 4, 32'h54, 1'b0, 32'h0));
      ir1_q.push_back(mk(t + 5, 32'h89AB_CDEF, 1'b0, 32'h0));
      @(negedge Clk); chk("stall_b0", {31'b0, bStall}, 32'h1);
      step();
      step();
      bIAddr = 32'h54;
      repeat (4) step();
      bIReq = 1'b0;
      @(negedge Clk); chk("hold_b6", bIData, 32'h89AB_CDEF);
      chk("b_drdata", bDRData, 32'h0);

      repeat (4) step();
      chk("left_issue0", 32'(iss_q.size()), 32'h0);
      chk("left_iready0", 32'(ir_q.size()), 32'h0);
      chk("left_dready0", 32'(dr_q.size()), 32'h0);
      chk("left_issue1", 32'(iss1_q.size()), 32'h0);
      chk("left_iready1", 32'(ir1_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
